spi_ram_sequencer: RTL

//  Command sequencer and port arbiter for the single-port RAM behind the SPI slave.

---
 rtl/spi_ram_sequencer_if.sv | 37 +++
 rtl/spi_ram_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_sequencer_if.sv
// Bundle of the SPI word stream, the auxiliary requester port and the RAM port.
// The master modport is the sequencer's view; the slave modport is the surrounding system.
interface spi_ram_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [9:0]        rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_gnt;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_rvalid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  rx_data, rx_valid, aux_req, aux_we, aux_addr, aux_wdata, ram_rdata,
    output tx_data, tx_valid, aux_gnt, aux_rdata, aux_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output rx_data, rx_valid, aux_req, aux_we, aux_addr, aux_wdata, ram_rdata,
    input  tx_data, tx_valid, aux_gnt, aux_rdata, aux_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/spi_ram_sequencer.sv
// Decodes SPI command words into RAM accesses and arbitrates the single RAM port
// between SPI traffic (priority, with a one-deep pending slot) and an auxiliary requester.
module spi_ram_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_ram_sequencer_if.master  bus,
  output logic                 busy,
  output logic                 err_seq
);
  typedef enum logic [1:0] {IDLE, SPI_RD, AUX_RD} state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [1:0]        lat_cnt_reg, lat_cnt_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic              wr_addr_ok_reg, wr_addr_ok_next;
  logic              rd_addr_ok_reg, rd_addr_ok_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [9:0]        pend_data_reg, pend_data_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [DATA_W-1:0] aux_rdata_reg, aux_rdata_next;
  logic              aux_rvalid_reg, aux_rvalid_next;

  logic              spi_issue;
  logic [9:0]        spi_word;
  logic              ram_en_c, ram_we_c, aux_gnt_c, err_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      wr_addr_reg    <= '0;
      rd_addr_reg    <= '0;
      wr_addr_ok_reg <= 1'b0;
      rd_addr_ok_reg <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      aux_rdata_reg  <= '0;
      aux_rvalid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lat_cnt_reg    <= lat_cnt_next;
      wr_addr_reg    <= wr_addr_next;
      rd_addr_reg    <= rd_addr_next;
      wr_addr_ok_reg <= wr_addr_ok_next;
      rd_addr_ok_reg <= rd_addr_ok_next;
      pend_valid_reg <= pend_valid_next;
      pend_data_reg  <= pend_data_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
      aux_rdata_reg  <= aux_rdata_next;
      aux_rvalid_reg <= aux_rvalid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lat_cnt_next    = lat_cnt_reg;
    wr_addr_next    = wr_addr_reg;
    rd_addr_next    = rd_addr_reg;
    wr_addr_ok_next = wr_addr_ok_reg;
    rd_addr_ok_next = rd_addr_ok_reg;
    pend_valid_next = pend_valid_reg;
    pend_data_next  = pend_data_reg;
    tx_data_next    = tx_data_reg;
    tx_valid_next   = 1'b0;
    aux_rdata_next  = aux_rdata_reg;
    aux_rvalid_next = 1'b0;
    spi_issue       = 1'b0;
    spi_word        = pend_data_reg;
    ram_en_c        = 1'b0;
    ram_we_c        = 1'b0;
    ram_addr_c      = '0;
    ram_wdata_c     = '0;
    aux_gnt_c       = 1'b0;
    err_c           = 1'b0;

    // Nothing reaches the RAM or the strobes while reset is held.
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (pend_valid_reg) begin
            // The slot frees as it issues, so a word arriving now takes its place.
            spi_issue       = 1'b1;
            spi_word        = pend_data_reg;
            pend_valid_next = bus.rx_valid;
            if (bus.rx_valid) pend_data_next = bus.rx_data;
          end else if (bus.rx_valid) begin
            spi_issue = 1'b1;
            spi_word  = bus.rx_data;
          end else if (bus.aux_req) begin
            aux_gnt_c  = 1'b1;
            ram_en_c   = 1'b1;
            ram_we_c   = bus.aux_we;
            ram_addr_c = bus.aux_addr;
            if (bus.aux_we) begin
              ram_wdata_c = bus.aux_wdata;
            end else begin
              state_next   = AUX_RD;
              lat_cnt_next = '0;
            end
          end
        end
        default: begin
          if (bus.rx_valid) begin
            if (pend_valid_reg) begin
              err_c = 1'b1;
            end else begin
              pend_valid_next = 1'b1;
              pend_data_next  = bus.rx_data;
            end
          end
          if (lat_cnt_reg == LAT_LAST) begin
            state_next = IDLE;
            if (state_reg == SPI_RD) begin
              tx_data_next  = bus.ram_rdata;
              tx_valid_next = 1'b1;
            end else begin
              aux_rdata_next  = bus.ram_rdata;
              aux_rvalid_next = 1'b1;
            end
          end else begin
            lat_cnt_next = lat_cnt_reg + 2'd1;
          end
        end
      endcase

      if (spi_issue) begin
        case (spi_word[9:8])
          2'b00: begin
            wr_addr_next    = ADDR_W'(spi_word[7:0]);
            wr_addr_ok_next = 1'b1;
          end
          2'b01: begin
            if (wr_addr_ok_reg) begin
              ram_en_c     = 1'b1;
              ram_we_c     = 1'b1;
              ram_addr_c   = wr_addr_reg;
              ram_wdata_c  = DATA_W'(spi_word[7:0]);
              wr_addr_next = wr_addr_reg + 1'b1;
            end else begin
              err_c = 1'b1;
            end
          end
          2'b10: begin
            rd_addr_next    = ADDR_W'(spi_word[7:0]);
            rd_addr_ok_next = 1'b1;
          end
          default: begin
            if (rd_addr_ok_reg) begin
              ram_en_c        = 1'b1;
              ram_addr_c      = rd_addr_reg;
              rd_addr_ok_next = 1'b0;
              state_next      = SPI_RD;
              lat_cnt_next    = '0;
            end else begin
              err_c = 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.ram_en     = ram_en_c;
  assign bus.ram_we     = ram_we_c;
  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_wdata  = ram_wdata_c;
  assign bus.aux_gnt    = aux_gnt_c;
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_valid   = tx_valid_reg;
  assign bus.aux_rdata  = aux_rdata_reg;
  assign bus.aux_rvalid = aux_rvalid_reg;
  assign err_seq        = err_c;
  assign busy           = (state_reg != IDLE) || pend_valid_reg;
endmodule
